sync_frame_receiver: RTL and testbench

Parametrised serial packet receiver. Shifts a 1-bit `din` stream into a `PKT_W`-bit window and matches the window against a masked sync pattern. It acquires frame lock only after `LOCK_CNT` matches spaced exactly `PKT_W` bits apart, and drops lock after `MISS_MAX` consecutive missed sync words. While locked it emits each aligned packet with a valid pulse, a sticky received flag and overrun detection. It sits directly behind the serial front end and feeds the configuration-register loader.

---
 rtl/sync_frame_pkg.sv | 30 +++
 rtl/sync_shift_window.sv | 47 ++++
 rtl/sync_frame_receiver.sv | 192 +++++++++++++++++++
 tb/tb_sync_frame_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_pkg
// Description : Shared types and constants for the sync frame receiver.
//               - state_e          : receiver framing state
//               - C_DEF_SYNC_MASK  : default sync mask (bits 62:58 and 8:0)
//               - C_DEF_SYNC_VALUE : default sync value
//               - cnt_width()      : width of the hit/miss counters
// Revision    : 1.0 - initial release
// ============================================================================
package sync_frame_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam logic [63:0] C_DEF_SYNC_MASK  = 64'h7C00_0000_0000_01FF;
   localparam logic [63:0] C_DEF_SYNC_VALUE = 64'h7C00_0000_0000_01FF;

   // Counters must hold values up to max(lock_cnt, miss_max) inclusive.
   function automatic int cnt_width(input int lock_cnt, input int miss_max);
      int m;
      m = (lock_cnt > miss_max) ? lock_cnt : miss_max;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_shift_window.sv
`default_nettype none
// ============================================================================
// Module      : sync_shift_window
// Description : PKT_W-bit serial shift window with masked sync comparator.
//               Ports:
//                 clk, rst       - clock, synchronous active-high reset
//                 en, din        - bit strobe and serial data (MSB first)
//                 win_next [W]   - window including the bit being sampled
//                 match          - masked sync compare of win_next
// Revision    : 1.0 - initial release
// ============================================================================
module sync_shift_window
   import sync_frame_pkg::*;
#(
   parameter int               PKT_W      = 64,
   parameter logic [PKT_W-1:0] SYNC_MASK  = PKT_W'(C_DEF_SYNC_MASK),
   parameter logic [PKT_W-1:0] SYNC_VALUE = PKT_W'(C_DEF_SYNC_VALUE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   output logic [PKT_W-1:0] win_next,
   output logic             match
);

   logic [PKT_W-1:0] win_q;
   logic [PKT_W-1:0] win_d;

   // The compare looks at the window as it will be after this bit, so the
   // FSM can act on the completing bit in the same cycle.
   always_comb begin
      win_next = {win_q[PKT_W-2:0], din};
      match    = ((win_next & SYNC_MASK) == (SYNC_VALUE & SYNC_MASK));
      win_d    = en ? win_next : win_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q <= '0;
      end else begin
         win_q <= win_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sync_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : sync_frame_receiver
// Description : Serial packet receiver with sync-word frame lock.
//               Ports:
//                 clk, rst        - clock, synchronous active-high reset
//                 en, din         - bit strobe and serial data (MSB first)
//                 pkt_rst         - clears pkt_rec / pkt_overrun
//                 dout [PKT_W]    - last emitted packet
//                 pkt_valid       - one-cycle pulse when dout updates
//                 pkt_rec         - sticky packet-received flag
//                 pkt_overrun     - sticky overrun flag
//                 locked          - frame lock indication
// Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_receiver
   import sync_frame_pkg::*;
#(
   parameter int               PKT_W      = 64,
   parameter logic [PKT_W-1:0] SYNC_MASK  = PKT_W'(C_DEF_SYNC_MASK),
   parameter logic [PKT_W-1:0] SYNC_VALUE = PKT_W'(C_DEF_SYNC_VALUE),
   parameter int               LOCK_CNT   = 2,
   parameter int               MISS_MAX   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             pkt_rst,
   output logic [PKT_W-1:0] dout,
   output logic             pkt_valid,
   output logic             pkt_rec,
   output logic             pkt_overrun,
   output logic             locked
);

   localparam int                BCNT_W      = $clog2(PKT_W);
   localparam int                CNT_W       = cnt_width(LOCK_CNT, MISS_MAX);
   localparam logic [BCNT_W-1:0] C_BCNT_LAST = BCNT_W'(PKT_W - 1);
   localparam logic [CNT_W-1:0]  C_LOCK_CNT  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  C_MISS_MAX  = CNT_W'(MISS_MAX);

   logic [PKT_W-1:0] win_next;
   logic             match;

   state_e           state_q,       state_d;
   logic [BCNT_W-1:0] bcnt_q,       bcnt_d;
   logic [CNT_W-1:0] hits_q,        hits_d;
   logic [CNT_W-1:0] miss_q,        miss_d;
   logic [PKT_W-1:0] dout_q,        dout_d;
   logic             pkt_valid_q,   pkt_valid_d;
   logic             pkt_rec_q,     pkt_rec_d;
   logic             pkt_overrun_q, pkt_overrun_d;
   logic             locked_q,      locked_d;

   logic             boundary;
   logic             emit;
   logic [CNT_W-1:0] hits_inc;
   logic [CNT_W-1:0] miss_inc;

   sync_shift_window #(
      .PKT_W      (PKT_W),
      .SYNC_MASK  (SYNC_MASK),
      .SYNC_VALUE (SYNC_VALUE)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .din      (din),
      .win_next (win_next),
      .match    (match)
   );

   always_comb begin
      state_d       = state_q;
      bcnt_d        = bcnt_q;
      hits_d        = hits_q;
      miss_d        = miss_q;
      dout_d        = dout_q;
      pkt_valid_d   = 1'b0;
      pkt_rec_d     = pkt_rec_q;
      pkt_overrun_d = pkt_overrun_q;
      emit          = 1'b0;
      boundary      = (bcnt_q == C_BCNT_LAST);
      hits_inc      = hits_q + CNT_W'(1);
      miss_inc      = miss_q + CNT_W'(1);

      if (en) begin
         bcnt_d = boundary ? '0 : bcnt_q + BCNT_W'(1);

         unique case (state_q)
            SEARCH: begin
               // A match here defines the alignment: this bit ends a frame.
               if (match) begin
                  bcnt_d = '0;
                  hits_d = CNT_W'(1);
                  if (LOCK_CNT == 1) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                     emit    = 1'b1;
                  end else begin
                     state_d = VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (match) begin
                     hits_d = hits_inc;
                     if (hits_inc == C_LOCK_CNT) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                        emit    = 1'b1;
                     end
                  end else begin
                     state_d = SEARCH;
                     hits_d  = '0;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (match) begin
                     miss_d = '0;
                     emit   = 1'b1;
                  end else if (miss_inc == C_MISS_MAX) begin
                     state_d = SEARCH;
                     hits_d  = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end
            default: begin
               state_d = SEARCH;
               hits_d  = '0;
               miss_d  = '0;
            end
         endcase
      end

      if (emit) begin
         dout_d        = win_next;
         pkt_valid_d   = 1'b1;
         pkt_rec_d     = 1'b1;
         pkt_overrun_d = pkt_overrun_q | pkt_rec_q;
      end

      // A clear coinciding with an emit acknowledges only the older packet.
      if (pkt_rst) begin
         pkt_overrun_d = 1'b0;
         if (!emit) begin
            pkt_rec_d = 1'b0;
         end
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= SEARCH;
         bcnt_q        <= '0;
         hits_q        <= '0;
         miss_q        <= '0;
         dout_q        <= '0;
         pkt_valid_q   <= 1'b0;
         pkt_rec_q     <= 1'b0;
         pkt_overrun_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         bcnt_q        <= bcnt_d;
         hits_q        <= hits_d;
         miss_q        <= miss_d;
         dout_q        <= dout_d;
         pkt_valid_q   <= pkt_valid_d;
         pkt_rec_q     <= pkt_rec_d;
         pkt_overrun_q <= pkt_overrun_d;
         locked_q      <= locked_d;
      end
   end

   assign dout        = dout_q;
   assign pkt_valid   = pkt_valid_q;
   assign pkt_rec     = pkt_rec_q;
   assign pkt_overrun = pkt_overrun_q;
   assign locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_frame_receiver
// Description : Self-checking bench for sync_frame_receiver (default params).
//               Directed scenarios followed by randomized frames, compared
//               every cycle against a bit-index based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_frame_receiver;

   localparam int          PKT_W    = 64;
   localparam int          LOCK_CNT = 2;
   localparam int          MISS_MAX = 2;
   localparam logic [63:0] MASK     = 64'h7C00_0000_0000_01FF;
   localparam logic [63:0] VAL      = 64'h7C00_0000_0000_01FF;

   localparam logic [63:0] FR_A   = 64'h7C00_0000_0000_01FF;
   localparam logic [63:0] FR_B   = 64'h7C12_3456_789A_BDFF;
   localparam logic [63:0] FR_C   = 64'h7CAB_CDEF_0123_45FF;
   localparam logic [63:0] FR_BAD = 64'h3C00_0000_0000_0000;
   // FR_F1 followed by FR_F2 forms a sync pattern 20 bits before the boundary.
   localparam logic [63:0] FR_F1  = 64'h7C00_0000_0007_C1FF;
   localparam logic [63:0] FR_F2  = 64'h7C00_0000_1FF0_01FF;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        din;
   logic        pkt_rst;
   logic [63:0] dout;
   logic        pkt_valid;
   logic        pkt_rec;
   logic        pkt_overrun;
   logic        locked;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: tracks absolute bit index and the index of the frame
   // anchor; alignment is a modulo test rather than a wrapping counter.
   logic [63:0] m_win;
   longint      m_n;
   longint      m_anchor;
   int          m_hits;
   int          m_miss;
   bit          m_locked;
   logic [63:0] m_dout;
   bit          m_valid, m_rec, m_ov;

   always #5 clk = ~clk;

   sync_frame_receiver #(
      .PKT_W      (PKT_W),
      .SYNC_MASK  (MASK),
      .SYNC_VALUE (VAL),
      .LOCK_CNT   (LOCK_CNT),
      .MISS_MAX   (MISS_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .din         (din),
      .pkt_rst     (pkt_rst),
      .dout        (dout),
      .pkt_valid   (pkt_valid),
      .pkt_rec     (pkt_rec),
      .pkt_overrun (pkt_overrun),
      .locked      (locked)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit d, input bit pr);
      bit m, aligned, emit;
      emit = 0;
      if (r) begin
         m_win = '0; m_n = 0; m_anchor = 0; m_hits = 0; m_miss = 0;
         m_locked = 0; m_dout = '0; m_valid = 0; m_rec = 0; m_ov = 0;
         return;
      end
      m_valid = 0;
      if (e) begin
         m_n++;
         m_win   = {m_win[62:0], d};
         m       = ((m_win & MASK) == (VAL & MASK));
         aligned = (m_n > m_anchor) && (((m_n - m_anchor) % PKT_W) == 0);
         if (!m_locked && m_hits == 0) begin
            if (m) begin
               m_anchor = m_n;
               m_hits   = 1;
               if (LOCK_CNT == 1) begin m_locked = 1; m_miss = 0; emit = 1; end
            end
         end else if (!m_locked) begin
            if (aligned) begin
               if (m) begin
                  m_hits++;
                  if (m_hits == LOCK_CNT) begin m_locked = 1; m_miss = 0; emit = 1; end
               end else begin
                  m_hits = 0;
               end
            end
         end else if (aligned) begin
            if (m) begin
               emit = 1; m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss == MISS_MAX) begin m_locked = 0; m_hits = 0; m_miss = 0; end
            end
         end
      end
      if (emit) begin
         m_dout  = m_win;
         m_valid = 1;
         m_ov    = m_ov | m_rec;
         m_rec   = 1;
      end
      if (pr) begin
         m_ov = 0;
         if (!emit) m_rec = 0;
      end
   endtask

   // Drive inputs (called at negedge), clock once, check at the next negedge.
   task automatic step(input bit e, input bit d, input bit pr, input bit r);
      en = e; din = d; pkt_rst = pr; rst = r;
      @(posedge clk);
      model_step(r, e, d, pr);
      @(negedge clk);
      check("dout",        dout,        m_dout);
      check("pkt_valid",   64'(pkt_valid),   64'(m_valid));
      check("pkt_rec",     64'(pkt_rec),     64'(m_rec));
      check("pkt_overrun", 64'(pkt_overrun), 64'(m_ov));
      check("locked",      64'(locked),      64'(m_locked));
   endtask

   task automatic send_bits(input logic [63:0] f, input int nbits, input int gap_at,
                            input int gap_len, input bit prst_last, input bit rnd_prst);
      for (int i = nbits - 1; i >= 0; i--) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end
         step(1'b1, f[i], (prst_last && i == 0) || (rnd_prst && $urandom_range(0, 49) == 0), 1'b0);
      end
   endtask

   task automatic send_frame(input logic [63:0] f);
      send_bits(f, 64, -1, 0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] f;
      int          gap_at, gap_len, extra;
      en = 0; din = 0; pkt_rst = 0; rst = 1;
      @(negedge clk);

      // Reset with din toggling
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("reset_dout", dout, 64'h0);
      check("reset_locked", 64'(locked), 64'h0);

      // Acquire lock: no emit after A, emit of B
      send_frame(FR_A);
      check("no_lock_after_A", 64'(locked), 64'h0);
      send_frame(FR_B);
      check("locked_after_B", 64'(locked), 64'h1);
      check("valid_after_B", 64'(pkt_valid), 64'h1);
      check("dout_B", dout, FR_B);
      check("rec_after_B", 64'(pkt_rec), 64'h1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("valid_one_cycle", 64'(pkt_valid), 64'h0);
      send_bits(FR_C, 63, -1, 0, 1'b0, 1'b0);

      // Overrun and clear
      send_frame(FR_C);
      check("overrun_set", 64'(pkt_overrun), 64'h1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("clr_rec", 64'(pkt_rec), 64'h0);
      check("clr_ov", 64'(pkt_overrun), 64'h0);
      check("clr_dout_hold", dout, FR_C);
      send_frame(FR_B);
      send_bits(FR_C, 64, -1, 0, 1'b1, 1'b0);
      check("clr_on_emit_rec", 64'(pkt_rec), 64'h1);
      check("clr_on_emit_ov", 64'(pkt_overrun), 64'h0);

      // Lose lock, then spurious off-aligned sync during VERIFY
      send_frame(FR_BAD);
      check("locked_after_1_miss", 64'(locked), 64'h1);
      send_frame(FR_BAD);
      check("unlocked_after_2_miss", 64'(locked), 64'h0);
      send_frame(FR_F1);
      check("no_emit_verify", 64'(pkt_valid), 64'h0);
      send_frame(FR_F2);
      check("lock_despite_spurious", 64'(locked), 64'h1);
      check("dout_F2", dout, FR_F2);

      // Enable gap mid-frame keeps alignment
      send_bits(FR_B, 64, 30, 10, 1'b0, 1'b0);
      check("gap_valid", 64'(pkt_valid), 64'h1);
      check("gap_dout", dout, FR_B);

      // Reset mid-VERIFY
      send_frame(FR_BAD);
      send_frame(FR_BAD);
      send_frame(FR_F1);
      send_bits(FR_B, 30, -1, 0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("midrst_dout", dout, 64'h0);
      check("midrst_locked", 64'(locked), 64'h0);
      send_bits(FR_B, 34, -1, 0, 1'b0, 1'b0);
      check("midrst_no_emit", 64'(pkt_valid), 64'h0);

      // Randomized frames with gaps, phase slips and random clears
      for (int k = 0; k < 40; k++) begin
         f = {$urandom, $urandom};
         if ($urandom_range(0, 9) < 8) f = (f & ~MASK) | (VAL & MASK);
         gap_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 62)) : -1;
         gap_len = $urandom_range(1, 5);
         send_bits(f, 64, gap_at, gap_len, 1'b0, 1'b1);
         if ($urandom_range(0, 9) == 0) begin
            extra = $urandom_range(1, 10);
            send_bits({$urandom, $urandom}, extra, -1, 0, 1'b0, 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
